// File: rtl/ctrl_pipe.sv
// ctrl_pipe: EX/MEM/WB control-rod pipeline with RAW/load-use stall, branch/jump flush.
// Optional forwarding selects enabled by defining CTRL_PIPE_FWD_EN.
module ctrl_pipe #(
   parameter int RA_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [9:0]      id_rod,
   input  logic [RA_W-1:0] id_rs_a,
   input  logic [RA_W-1:0] id_rs_b,
   input  logic [RA_W-1:0] id_rd,
   input  logic            br_taken,
   output logic            stall,
   output logic            flush,
   output logic            ex_valid,
   output logic            mem_valid,
   output logic            wb_valid,
   output logic [9:0]      ex_rod,
   output logic [9:0]      mem_rod,
   output logic [9:0]      wb_rod,
   output logic [RA_W-1:0] ex_rd,
   output logic [RA_W-1:0] mem_rd,
   output logic [RA_W-1:0] wb_rd,
   output logic [1:0]      ex_fwd_a,
   output logic [1:0]      ex_fwd_b,
   output logic            wb_we
);
   typedef struct packed {
      logic            v;
      logic [9:0]      rod;
      logic [RA_W-1:0] rd;
   } stage_t;

   stage_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [2:0] hit_a, hit_b;
   logic       haz, br_flush, issue;

   function automatic logic writes(stage_t s, logic [RA_W-1:0] rs);
      return s.v & s.rod[6] & (s.rd == rs);
   endfunction

   always_comb begin
      hit_a = {writes(wb_q, id_rs_a), writes(mem_q, id_rs_a), writes(ex_q, id_rs_a)}
              & {3{id_valid & id_rod[9]}};
      hit_b = {writes(wb_q, id_rs_b), writes(mem_q, id_rs_b), writes(ex_q, id_rs_b)}
              & {3{id_valid & id_rod[8]}};
      br_flush = ex_q.v & ex_q.rod[3] & br_taken;
`ifdef CTRL_PIPE_FWD_EN
      haz = (hit_a[0] | hit_b[0]) & ex_q.rod[4];
      fwd_a_d = hit_a[0] ? 2'b01 : hit_a[1] ? 2'b10 : hit_a[2] ? 2'b11 : 2'b00;
      fwd_b_d = hit_b[0] ? 2'b01 : hit_b[1] ? 2'b10 : hit_b[2] ? 2'b11 : 2'b00;
`else
      haz = |{hit_a, hit_b};
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
`endif
      stall = !rst & haz & !br_flush;
      flush = !rst & (br_flush | (id_valid & id_rod[7] & !stall));
      issue = id_valid & !stall & !br_flush;
      ex_d = issue ? {1'b1, id_rod, id_rd} : '0;
      fwd_a_d = issue ? fwd_a_d : 2'b00;
      fwd_b_d = issue ? fwd_b_d : 2'b00;
      mem_d = ex_q;
      wb_d = mem_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         fwd_a_q <= 2'b00;
         fwd_b_q <= 2'b00;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign ex_valid  = ex_q.v;
   assign mem_valid = mem_q.v;
   assign wb_valid  = wb_q.v;
   assign ex_rod    = ex_q.rod;
   assign mem_rod   = mem_q.rod;
   assign wb_rod    = wb_q.rod;
   assign ex_rd     = ex_q.rd;
   assign mem_rd    = mem_q.rd;
   assign wb_rd     = wb_q.rd;
   assign ex_fwd_a  = fwd_a_q;
   assign ex_fwd_b  = fwd_b_q;
   assign wb_we     = wb_q.v & wb_q.rod[6];
endmodule
